pe_writeback_pipe: RTL and testbench

- Sits directly downstream of the PE array, in parallel with the bypass-select stage.
- Registers each PE result to produce the one-cycle-old history (pe_o_before, opcode_before, opcode_delay) that bypass selection consumes.
- Queues results in a small FIFO and drives the alpha/beta storage write port.
- Applies stage-dependent lane masking and absorbs storage back-pressure.

---
 rtl/polar_pkg.sv | 27 ++
 rtl/pe_writeback_mask.sv | 3 +
 rtl/pe_writeback_pipe_wb_lane_mask.sv | 42 ++++
 rtl/pe_writeback_pipe.sv | 130 +++++++++++++
 tb/tb_pe_writeback_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/polar_pkg.sv
// Shared opcode map, history reset value, geometry constants and node-size helper
// for the polar decoder write-back path.
package polar_pkg;

    localparam logic [3:0] TYPE1FUN  = 4'd0;
    localparam logic [3:0] TYPE2FUN  = 4'd1;
    localparam logic [3:0] BOTTOMFUN = 4'd2;
    localparam logic [3:0] TYPE3FUN  = 4'd3;

    // Decodes as none of the bypass-relevant operations.
    localparam logic [3:0] HIST_RST_OP = 4'hF;

    localparam int PE_LANES = 64;
    localparam int WIDTH    = PE_LANES << 2;
    localparam int DEPTH    = PE_LANES << 3;

    // Index of the highest set bit; exact log2 for the power-of-two node sizes.
    function automatic logic [3:0] log2(input logic [10:0] n);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (n[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_writeback_mask.sv
// Empty module; the lane mask generator lives in pe_writeback_pipe_wb_lane_mask.sv.
module pe_writeback_mask_unused;
endmodule

// File: rtl/pe_writeback_pipe_wb_lane_mask.sv
// Combinational lane mask from node size: all-ones Q-bit fields for active lanes,
// zero for lanes at or above the active count in each half.
module wb_lane_mask #(
    parameter int P = 64,
    parameter int Q = 6
) (
    input  logic [10:0]      i_nv_i,
    output logic [2*P*Q-1:0] mask_o
);

    logic legal;
    int   lo_l;
    int   hi_l;

    assign legal = (i_nv_i >= 11'd2) && (i_nv_i <= 11'd512) &&
                   ((i_nv_i & (i_nv_i - 11'd1)) == 11'd0);

    always_comb begin
        lo_l   = 0;
        hi_l   = 0;
        mask_o = '0;
        if (!legal) begin
            lo_l = 0;
            hi_l = 0;
        end else if (i_nv_i >= 11'd256) begin
            lo_l = P;
            hi_l = P;
        end else if (i_nv_i >= 11'd4) begin
            lo_l = (int'(i_nv_i >> 2) > P) ? P : int'(i_nv_i >> 2);
            hi_l = lo_l;
        end else begin
            // Bottom node: two lanes of the low half only.
            lo_l = 2;
            hi_l = 0;
        end
        for (int i = 0; i < P; i++) begin
            mask_o[i*Q +: Q]     = (i < lo_l) ? {Q{1'b1}} : {Q{1'b0}};
            mask_o[(P+i)*Q +: Q] = (i < hi_l) ? {Q{1'b1}} : {Q{1'b0}};
        end
    end

endmodule

// File: rtl/pe_writeback_pipe.sv
// PE result history registers plus masked write-back FIFO to alpha/beta storage.
// Optional sticky overflow flag enabled by macro WB_OVF_DETECT_EN.
module pe_writeback_pipe
    import polar_pkg::*;
#(
    parameter int P          = 64,
    parameter int Q          = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pe_vld,
    output logic              pe_rdy,
    input  logic [2*P*Q-1:0]  pe_o,
    input  logic [3:0]        opcode,
    input  logic [10:0]       I_Nv,
    input  logic [3:0]        channel_cnt,
    output logic [2*P*Q-1:0]  pe_o_before,
    output logic [3:0]        opcode_before,
    output logic [3:0]        opcode_delay,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic              wr_alpha,
    output logic [AW-1:0]     wr_addr,
    output logic [2*P*Q-1:0]  wr_data,
    output logic              ovf
);

    localparam int DW = 2*P*Q;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          alpha;
    } wb_entry_t;

    wb_entry_t      mem_q [FIFO_DEPTH];
    wb_entry_t      push_entry;
    wb_entry_t      head;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  lane_mask;
    logic [DW-1:0]  pe_o_before_q;
    logic [3:0]     opcode_before_q, opcode_delay_q;
    logic           push, pop;

    wb_lane_mask #(.P(P), .Q(Q)) u_lane_mask (
        .i_nv_i (I_Nv),
        .mask_o (lane_mask)
    );

    assign pe_rdy = (cnt_q != CW'(FIFO_DEPTH));
    assign push   = pe_vld && pe_rdy;
    assign wr_en  = (cnt_q != '0);
    assign pop    = wr_en && wr_ready;

    always_comb begin
        push_entry.data  = pe_o & lane_mask;
        push_entry.addr  = AW'({log2(I_Nv), channel_cnt});
        push_entry.alpha = (opcode == TYPE1FUN) || (opcode == TYPE2FUN);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            pe_o_before_q   <= '0;
            opcode_before_q <= HIST_RST_OP;
            opcode_delay_q  <= HIST_RST_OP;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                pe_o_before_q   <= pe_o;
                opcode_delay_q  <= opcode_before_q;
                opcode_before_q <= opcode;
            end
        end
    end

    // NOTE: storage is not reset; outputs are gated by !empty, so stale entries never reach the port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head        = mem_q[rd_ptr_q];
    assign wr_data     = wr_en ? head.data  : '0;
    assign wr_addr     = wr_en ? head.addr  : '0;
    assign wr_alpha    = wr_en ? head.alpha : 1'b0;

    assign pe_o_before   = pe_o_before_q;
    assign opcode_before = opcode_before_q;
    assign opcode_delay  = opcode_delay_q;

`ifdef WB_OVF_DETECT_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ovf_q <= 1'b0;
        else if (pe_vld && !pe_rdy)    ovf_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_chk: assert (!(pe_vld && !pe_rdy))
                else $warning("pe_writeback_pipe: result offered while write-back queue full");
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pe_writeback_pipe.sv
// Directed bench for pe_writeback_pipe: history, masking, back-pressure, reset, overflow.
module tb_pe_writeback_pipe;

    localparam int P  = 64;
    localparam int Q  = 6;
    localparam int AW = 8;
    localparam int DW = 2*P*Q;

    logic          clk, rst;
    logic          pe_vld, pe_rdy;
    logic [DW-1:0] pe_o, pe_o_before, wr_data;
    logic [3:0]    opcode, opcode_before, opcode_delay, channel_cnt;
    logic [10:0]   I_Nv;
    logic          wr_en, wr_ready, wr_alpha, ovf;
    logic [AW-1:0] wr_addr;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_OVF_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    pe_writeback_pipe #(.P(P), .Q(Q), .FIFO_DEPTH(4), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pe_vld        (pe_vld),
        .pe_rdy        (pe_rdy),
        .pe_o          (pe_o),
        .opcode        (opcode),
        .I_Nv          (I_Nv),
        .channel_cnt   (channel_cnt),
        .pe_o_before   (pe_o_before),
        .opcode_before (opcode_before),
        .opcode_delay  (opcode_delay),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_alpha      (wr_alpha),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .ovf           (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill(input logic [Q-1:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < 2*P; i++) d[i*Q +: Q] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] masked(input logic [Q-1:0] v, input int lo, input int hi);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < P; i++) begin
            if (i < lo) d[i*Q +: Q]     = v;
            if (i < hi) d[(P+i)*Q +: Q] = v;
        end
        return d;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [10:0] nv,
                         input logic [3:0] ch, input logic [Q-1:0] v);
        pe_vld      = 1'b1;
        opcode      = op;
        I_Nv        = nv;
        channel_cnt = ch;
        pe_o        = fill(v);
    endtask

    initial begin
        rst = 1'b1; pe_vld = 1'b0; pe_o = '0; opcode = 4'd0;
        I_Nv = 11'd2; channel_cnt = 4'd0; wr_ready = 1'b1;
        #1;
        check("rst_pe_rdy",   DW'(pe_rdy), DW'(1'b1));
        check("rst_wr_en",    DW'(wr_en), '0);
        check("rst_op_bef",   DW'(opcode_before), DW'(4'hF));
        check("rst_op_dly",   DW'(opcode_delay), DW'(4'hF));
        check("rst_pe_bef",   pe_o_before, '0);
        check("rst_wr_data",  wr_data, '0);
        check("rst_wr_addr",  DW'(wr_addr), '0);
        check("rst_ovf",      DW'(ovf), '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // Single result, I_Nv=128 -> 32 active lanes per half.
        drive(4'd0, 11'd128, 4'd0, 6'h15);
        tick();
        pe_vld = 1'b0;
        check("single_wr_en",    DW'(wr_en), DW'(1'b1));
        check("single_alpha",    DW'(wr_alpha), DW'(1'b1));
        check("single_addr",     DW'(wr_addr), DW'(8'h70));
        check("single_data",     wr_data, masked(6'h15, 32, 32));
        check("single_pe_bef",   pe_o_before, fill(6'h15));
        tick();
        check("single_drained",  DW'(wr_en), '0);

        // History chain; I_Nv=4 leaves one lane per half.
        drive(4'd1, 11'd4, 4'd2, 6'h2A);
        tick();
        check("i4_data",  wr_data, masked(6'h2A, 1, 1));
        check("i4_addr",  DW'(wr_addr), DW'(8'h22));
        drive(4'd3, 11'd4, 4'd2, 6'h2A);
        tick();
        drive(4'd2, 11'd4, 4'd2, 6'h2A);
        tick();
        pe_vld = 1'b0;
        check("hist_before", DW'(opcode_before), DW'(4'd2));
        check("hist_delay",  DW'(opcode_delay), DW'(4'd3));
        repeat (3) tick();
        check("hist_hold_before", DW'(opcode_before), DW'(4'd2));
        check("hist_hold_delay",  DW'(opcode_delay), DW'(4'd3));
        check("hist_idle_wr_en",  DW'(wr_en), '0);

        // Back-pressure: five offers into a four-entry queue.
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(4'd3, 11'd512, 4'(k), 6'(k + 1));
            #1;
            check($sformatf("bp_rdy_%0d", k), DW'(pe_rdy), DW'(k < 4));
            tick();
        end
        pe_vld = 1'b0;
        check("bp_pe_bef",  pe_o_before, fill(6'd4));
        check("bp_op_bef",  DW'(opcode_before), DW'(4'd3));
        check("bp_ovf",     DW'(ovf), DW'(OVF_EXP));
        for (int s = 0; s < 2; s++) begin
            check($sformatf("stall_en_%0d", s),   DW'(wr_en), DW'(1'b1));
            check($sformatf("stall_data_%0d", s), wr_data, fill(6'd1));
            check($sformatf("stall_addr_%0d", s), DW'(wr_addr), DW'(8'h90));
            tick();
        end
        wr_ready = 1'b1;
        #1;
        check("full_rdy_with_pop", DW'(pe_rdy), '0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_en_%0d", k),    DW'(wr_en), DW'(1'b1));
            check($sformatf("drain_data_%0d", k),  wr_data, fill(6'(k + 1)));
            check($sformatf("drain_addr_%0d", k),  DW'(wr_addr), DW'(8'h90 + k));
            check($sformatf("drain_alpha_%0d", k), DW'(wr_alpha), '0);
            tick();
        end
        check("drain_empty", DW'(wr_en), '0);

        // Bottom node: two lanes, low half only.
        drive(4'd2, 11'd2, 4'd0, 6'h3F);
        tick();
        pe_vld = 1'b0;
        check("bottom_alpha", DW'(wr_alpha), '0);
        check("bottom_addr",  DW'(wr_addr), DW'(8'h10));
        check("bottom_data",  wr_data, masked(6'h3F, 2, 0));
        tick();

        // Illegal node size zeroes all data.
        drive(4'd0, 11'd3, 4'd0, 6'h3F);
        tick();
        pe_vld = 1'b0;
        check("illegal_en",   DW'(wr_en), DW'(1'b1));
        check("illegal_data", wr_data, '0);
        tick();

        // Reset with three entries queued.
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(4'd1, 11'd16, 4'(k), 6'h0C);
            tick();
        end
        pe_vld = 1'b0;
        check("pre_rst_en",  DW'(wr_en), DW'(1'b1));
        check("pre_rst_ovf", DW'(ovf), DW'(OVF_EXP));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_wr_en",  DW'(wr_en), '0);
        check("mid_rst_rdy",    DW'(pe_rdy), DW'(1'b1));
        check("mid_rst_op_bef", DW'(opcode_before), DW'(4'hF));
        check("mid_rst_op_dly", DW'(opcode_delay), DW'(4'hF));
        check("mid_rst_pe_bef", pe_o_before, '0);
        check("mid_rst_data",   wr_data, '0);
        check("mid_rst_ovf",    DW'(ovf), '0);
        @(negedge clk) rst = 1'b0;
        wr_ready = 1'b1;
        tick();
        check("post_rst_wr_en", DW'(wr_en), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
